msg_display_mux: RTL and testbench

Parametrised multiplexed 7-segment message driver, successor to the fixed four-digit end-of-game banner. Holds a loadable message of MSG_LEN 5-bit character codes and scans a DIGITS-wide window onto a common-anode display, one digit per refresh slot. Supports static, scrolling, blinking and blank modes. It sits between game-state logic and the board display pins.

---
 rtl/msg_display_mux_if.sv | 31 +++
 rtl/msg_display_mux.sv | 184 ++++++++++++++++++
 tb/tb_msg_display_mux.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msg_display_mux_if.sv
// msg_display_mux_if: message/mode bus and display pins.
// master = game logic side, slave = display mux.
interface msg_display_mux_if #(
    parameter int DIGITS  = 4,
    parameter int MSG_LEN = 8
);
    logic                 msg_load;
    logic [5*MSG_LEN-1:0] msg_data;
    logic [1:0]           mode;
    logic [6:0]           seg;
    logic [DIGITS-1:0]    an;
    logic                 wrap;

    modport master (
        output msg_load,
        output msg_data,
        output mode,
        input  seg,
        input  an,
        input  wrap
    );

    modport slave (
        input  msg_load,
        input  msg_data,
        input  mode,
        output seg,
        output an,
        output wrap
    );
endinterface

// File: rtl/msg_display_mux.sv
// msg_display_mux: scans a DIGITS-wide window of a loadable
// message onto a common-anode 7-segment display.
module msg_display_mux #(
    parameter int DIGITS      = 4,
    parameter int MSG_LEN     = 8,
    parameter int REFRESH_DIV = 1,
    parameter int SCROLL_DIV  = 250,
    parameter int BLINK_DIV   = 500
) (
    input logic              slclk,
    input logic              rst,
    msg_display_mux_if.slave bus
);
    localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int OW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [1:0] M_SCROLL = 2'b01;
    localparam logic [1:0] M_BLINK  = 2'b10;
    localparam logic [1:0] M_BLANK  = 2'b11;

    logic [4:0]        chars_q [MSG_LEN];
    logic [4:0]        chars_d [MSG_LEN];
    logic [OW-1:0]     off_q, off_d;
    logic [SW-1:0]     sc_q, sc_d;
    logic [BW-1:0]     bc_q, bc_d;
    logic              on_q, on_d;
    logic              wrap_q, wrap_d;
    logic [RW-1:0]     rc_q;
    logic [PW-1:0]     pos_q;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              slot;
    logic [OW:0]       sum;
    logic [OW-1:0]     idx;
    logic [4:0]        code;
    logic              blank;

    function automatic logic [6:0] font(input logic [4:0] c);
        logic [6:0] s;
        case (c)
            5'd0:    s = 7'b0000001;
            5'd1:    s = 7'b1001111;
            5'd2:    s = 7'b0010010;
            5'd3:    s = 7'b0000110;
            5'd4:    s = 7'b1001100;
            5'd5:    s = 7'b0100100;
            5'd6:    s = 7'b0100000;
            5'd7:    s = 7'b0001111;
            5'd8:    s = 7'b0000000;
            5'd9:    s = 7'b0000100;
            5'd10:   s = 7'b0001000;
            5'd11:   s = 7'b1100000;
            5'd12:   s = 7'b0110001;
            5'd13:   s = 7'b1000010;
            5'd14:   s = 7'b0110000;
            5'd15:   s = 7'b0111000;
            5'd16:   s = 7'b1110001;
            5'd17:   s = 7'b1100010;
            5'd18:   s = 7'b0100100;
            5'd19:   s = 7'b1111010;
            5'd20:   s = 7'b1111110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign slot = (rc_q == '0);

    // Next message, scroll and blink state; a load overrides a step.
    always_comb begin
        for (int i = 0; i < MSG_LEN; i++) begin
            chars_d[i] = chars_q[i];
        end
        off_d  = off_q;
        sc_d   = sc_q;
        bc_d   = bc_q;
        on_d   = on_q;
        wrap_d = 1'b0;
        if (bus.mode == M_BLINK) begin
            if (bc_q == BW'(BLINK_DIV - 1)) begin
                bc_d = '0;
                on_d = !on_q;
            end else begin
                bc_d = bc_q + 1'b1;
            end
        end else begin
            bc_d = '0;
            on_d = 1'b1;
        end
        if (bus.msg_load) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                chars_d[i] = bus.msg_data[5*i +: 5];
            end
            off_d = '0;
            sc_d  = '0;
            on_d  = 1'b1;
        end else if (bus.mode == M_SCROLL) begin
            if (sc_q == SW'(SCROLL_DIV - 1)) begin
                sc_d = '0;
                if (off_q == OW'(MSG_LEN - 1)) begin
                    off_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    off_d = off_q + 1'b1;
                end
            end else begin
                sc_d = sc_q + 1'b1;
            end
        end
    end

    // Slot contents from post-edge state, so changes show at once.
    always_comb begin
        if (bus.mode == M_SCROLL) begin
            sum = {1'b0, off_d} + (OW+1)'(pos_q);
        end else begin
            sum = (OW+1)'(pos_q);
        end
        if (sum >= (OW+1)'(MSG_LEN)) begin
            sum = sum - (OW+1)'(MSG_LEN);
        end
        idx   = sum[OW-1:0];
        code  = chars_d[idx];
        blank = (bus.mode == M_BLANK) ||
                (bus.mode == M_BLINK && !on_d);
        seg_d = blank ? 7'h7f : font(code);
        an_d  = '1;
        if (!blank) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (i == DIGITS - 1 - int'(pos_q)) begin
                    an_d[i] = 1'b0;
                end
            end
        end
    end

    // State registers; seg/an only move on slot edges.
    always_ff @(posedge slclk) begin
        if (rst) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                chars_q[i] <= 5'd31;
            end
            off_q  <= '0;
            sc_q   <= '0;
            bc_q   <= '0;
            on_q   <= 1'b1;
            wrap_q <= 1'b0;
            rc_q   <= '0;
            pos_q  <= '0;
            seg_q  <= '1;
            an_q   <= '1;
        end else begin
            for (int i = 0; i < MSG_LEN; i++) begin
                chars_q[i] <= chars_d[i];
            end
            off_q  <= off_d;
            sc_q   <= sc_d;
            bc_q   <= bc_d;
            on_q   <= on_d;
            wrap_q <= wrap_d;
            if (rc_q == RW'(REFRESH_DIV - 1)) begin
                rc_q <= '0;
            end else begin
                rc_q <= rc_q + 1'b1;
            end
            if (slot) begin
                seg_q <= seg_d;
                an_q  <= an_d;
                if (pos_q == PW'(DIGITS - 1)) begin
                    pos_q <= '0;
                end else begin
                    pos_q <= pos_q + 1'b1;
                end
            end
        end
    end

    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_msg_display_mux.sv
// tb_msg_display_mux: two DUTs (REFRESH_DIV 1 and 3) on one
// stimulus stream, checked against a behavioural model.
module tb_msg_display_mux;
    localparam int D  = 4;
    localparam int ML = 8;
    localparam int SD = 10;
    localparam int BD = 8;

    logic        slclk = 1'b0;
    logic        rst   = 1'b1;
    logic        ld    = 1'b0;
    logic [39:0] data  = '0;
    logic [1:0]  md    = 2'b00;
    int          vecs  = 0;
    int          errs  = 0;

    localparam logic [39:0] LOSS = {5'd31, 5'd31, 5'd31, 5'd31,
                                    5'd18, 5'd18, 5'd17, 5'd16};
    localparam logic [39:0] SEQ  = {5'd7, 5'd6, 5'd5, 5'd4,
                                    5'd3, 5'd2, 5'd1, 5'd0};

    always #5 slclk = ~slclk;

    msg_display_mux_if #(.DIGITS(D), .MSG_LEN(ML)) ia ();
    msg_display_mux_if #(.DIGITS(D), .MSG_LEN(ML)) ib ();

    assign ia.msg_load = ld;
    assign ia.msg_data = data;
    assign ia.mode     = md;
    assign ib.msg_load = ld;
    assign ib.msg_data = data;
    assign ib.mode     = md;

    msg_display_mux #(
        .DIGITS(D), .MSG_LEN(ML), .REFRESH_DIV(1),
        .SCROLL_DIV(SD), .BLINK_DIV(BD)
    ) dut_a (
        .slclk(slclk),
        .rst(rst),
        .bus(ia)
    );

    msg_display_mux #(
        .DIGITS(D), .MSG_LEN(ML), .REFRESH_DIV(3),
        .SCROLL_DIV(SD), .BLINK_DIV(BD)
    ) dut_b (
        .slclk(slclk),
        .rst(rst),
        .bus(ib)
    );

    function automatic logic [6:0] font(input int c);
        case (c)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            15: return 7'b0111000;
            16: return 7'b1110001;
            17: return 7'b1100010;
            18: return 7'b0100100;
            19: return 7'b1111010;
            20: return 7'b1111110;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int rdiv(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Reference model: message, scroll count since load, blink phase.
    int         m_buf [ML];
    int         m_k = 0;
    int         m_bc = 0;
    bit         m_on = 1'b1;
    int         m_n [2];
    logic [6:0] e_seg [2];
    logic [3:0] e_an [2];
    logic       e_wrap = 1'b0;

    always @(posedge slclk) begin
        if (rst) begin
            for (int c = 0; c < ML; c++) m_buf[c] = 31;
            m_k    = 0;
            m_bc   = 0;
            m_on   = 1'b1;
            e_wrap = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_n[i]   = 0;
                e_seg[i] = 7'h7f;
                e_an[i]  = 4'hf;
            end
        end else begin
            e_wrap = 1'b0;
            if (md == 2'd2) begin
                m_bc++;
                if (m_bc == BD) begin
                    m_bc = 0;
                    m_on = !m_on;
                end
            end else begin
                m_bc = 0;
                m_on = 1'b1;
            end
            if (ld) begin
                for (int c = 0; c < ML; c++) m_buf[c] = int'(data[5*c +: 5]);
                m_k  = 0;
                m_on = 1'b1;
            end else if (md == 2'd1) begin
                m_k++;
                if (m_k % (SD * ML) == 0) e_wrap = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                if (m_n[i] % rdiv(i) == 0) begin
                    int p;
                    int c;
                    p = (m_n[i] / rdiv(i)) % D;
                    if (md == 2'd1) c = m_buf[((m_k / SD) + p) % ML];
                    else c = m_buf[p];
                    if (md == 2'd3 || (md == 2'd2 && !m_on)) begin
                        e_seg[i] = 7'h7f;
                        e_an[i]  = 4'hf;
                    end else begin
                        e_seg[i] = font(c);
                        e_an[i]  = 4'hf & ~(4'h8 >> p);
                    end
                end
                m_n[i]++;
            end
        end
    end

    function automatic logic [23:0] got();
        return {ia.seg, ia.an, ia.wrap, ib.seg, ib.an, ib.wrap};
    endfunction

    function automatic logic [23:0] want();
        return {e_seg[0], e_an[0], e_wrap, e_seg[1], e_an[1], e_wrap};
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        ld  = 1'b0;
        md  = 2'b00;
        @(negedge slclk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] rs;
        rs  = {7'h7f, 4'hf, 1'b0, 7'h7f, 4'hf, 1'b0};
        rst = 1'b1;
        ld  = 1'b0;
        md  = 2'b00;
        @(negedge slclk);
        if (got() !== rs) begin
            errs++;
            $display("FAIL reset_state got=%h want=%h", got(), rs);
        end
        vecs++;
        ld   = 1'b1;
        data = SEQ;
        @(negedge slclk);
        if (got() !== rs) begin
            errs++;
            $display("FAIL reset_load got=%h want=%h", got(), rs);
        end
        vecs++;
        rst = 1'b0;
        ld  = 1'b0;
        @(negedge slclk);
        if ({ia.seg, ia.an} !== {7'h7f, 4'b0111}) begin
            errs++;
            $display("FAIL first_slot got=%h want=%h",
                     {ia.seg, ia.an}, {7'h7f, 4'b0111});
        end
        vecs++;
    endtask

    task automatic test_static();
        logic [6:0] ls [4];
        logic [21:0] ex;
        ls[0] = 7'b1110001;
        ls[1] = 7'b1100010;
        ls[2] = 7'b0100100;
        ls[3] = 7'b0100100;
        apply_reset();
        ld   = 1'b1;
        data = LOSS;
        md   = 2'b00;
        for (int j = 0; j < 24; j++) begin
            @(negedge slclk);
            ld = 1'b0;
            ex = {ls[j % 4], 4'hf & ~(4'h8 >> (j % 4)),
                  ls[(j / 3) % 4], 4'hf & ~(4'h8 >> ((j / 3) % 4))};
            if ({ia.seg, ia.an, ib.seg, ib.an} !== ex) begin
                errs++;
                $display("FAIL static_loss j=%0d got=%h want=%h",
                         j, {ia.seg, ia.an, ib.seg, ib.an}, ex);
            end
            vecs++;
            if (got() !== want()) begin
                errs++;
                $display("FAIL static_model j=%0d got=%h want=%h",
                         j, got(), want());
            end
            vecs++;
        end
    endtask

    task automatic test_scroll();
        int wraps;
        int wj;
        wraps = 0;
        wj    = -1;
        apply_reset();
        ld   = 1'b1;
        data = SEQ;
        md   = 2'b01;
        for (int j = 0; j < 95; j++) begin
            @(negedge slclk);
            ld = 1'b0;
            if (ia.wrap) begin
                wraps++;
                wj = j;
            end
            if (j == 12 && {ia.seg, ia.an} !== {7'b1001111, 4'b0111}) begin
                errs++;
                $display("FAIL scroll_step got=%h want=%h",
                         {ia.seg, ia.an}, {7'b1001111, 4'b0111});
            end
            if (j == 12) vecs++;
            if (got() !== want()) begin
                errs++;
                $display("FAIL scroll_model j=%0d got=%h want=%h",
                         j, got(), want());
            end
            vecs++;
        end
        if (wraps != 1 || wj != 80) begin
            errs++;
            $display("FAIL scroll_wrap got=%0d@%0d want=1@80", wraps, wj);
        end
        vecs++;
    endtask

    task automatic test_blink();
        bit off;
        apply_reset();
        ld   = 1'b1;
        data = LOSS;
        md   = 2'b00;
        @(negedge slclk);
        ld = 1'b0;
        md = 2'b10;
        for (int j = 0; j < 40; j++) begin
            @(negedge slclk);
            off = (((j + 1) / BD) % 2) == 1;
            if ((ia.an === 4'hf) !== off) begin
                errs++;
                $display("FAIL blink_phase j=%0d got=%b want_off=%b",
                         j, ia.an, off);
            end
            vecs++;
            if (got() !== want()) begin
                errs++;
                $display("FAIL blink_model j=%0d got=%h want=%h",
                         j, got(), want());
            end
            vecs++;
        end
        for (int j = 0; j < 20; j++) begin
            @(negedge slclk);
            if (ia.an === 4'hf && ld == 1'b0) begin
                ld   = 1'b1;
                data = SEQ;
                @(negedge slclk);
                ld = 1'b0;
                if (ia.an === 4'hf) begin
                    errs++;
                    $display("FAIL blink_load got=%b want=on", ia.an);
                end
                vecs++;
            end
            if (got() !== want()) begin
                errs++;
                $display("FAIL blink_load_model j=%0d got=%h want=%h",
                         j, got(), want());
            end
            vecs++;
        end
    endtask

    task automatic test_load_step();
        apply_reset();
        ld   = 1'b1;
        data = SEQ;
        md   = 2'b01;
        for (int j = 0; j < 90; j++) begin
            @(negedge slclk);
            if (j == 80 && (ia.wrap !== 1'b0 || ib.wrap !== 1'b0)) begin
                errs++;
                $display("FAIL load_step_wrap got=%b%b want=00",
                         ia.wrap, ib.wrap);
            end
            if (j == 80) vecs++;
            if (got() !== want()) begin
                errs++;
                $display("FAIL load_step_model j=%0d got=%h want=%h",
                         j, got(), want());
            end
            vecs++;
            ld   = (j == 79);
            data = LOSS;
        end
        ld = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [11:0] ex;
        apply_reset();
        ld   = 1'b1;
        data = SEQ;
        md   = 2'b01;
        for (int j = 0; j < 79; j++) begin
            @(negedge slclk);
            ld = 1'b0;
            if (got() !== want()) begin
                errs++;
                $display("FAIL mid_model j=%0d got=%h want=%h",
                         j, got(), want());
            end
            vecs++;
        end
        rst = 1'b1;
        @(negedge slclk);
        rst = 1'b0;
        ex  = {7'h7f, 4'hf, 1'b0};
        if ({ia.seg, ia.an, ia.wrap} !== ex ||
            {ib.seg, ib.an, ib.wrap} !== ex) begin
            errs++;
            $display("FAIL mid_reset got=%h want=%h", got(), {ex, ex});
        end
        vecs++;
        for (int j = 0; j < 8; j++) begin
            @(negedge slclk);
            ex = {7'h7f, 4'hf & ~(4'h8 >> (j % 4)), 1'b0};
            if ({ia.seg, ia.an, ia.wrap} !== ex) begin
                errs++;
                $display("FAIL mid_blank j=%0d got=%h want=%h",
                         j, {ia.seg, ia.an, ia.wrap}, ex);
            end
            vecs++;
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int j = 0; j < 1500; j++) begin
            @(negedge slclk);
            if (got() !== want()) begin
                errs++;
                $display("FAIL random_model j=%0d got=%h want=%h",
                         j, got(), want());
            end
            vecs++;
            rst = ($urandom_range(0, 299) == 0);
            ld  = ($urandom_range(0, 99) == 0);
            if (ld) begin
                for (int c = 0; c < ML; c++) begin
                    data[5*c +: 5] = 5'($urandom_range(0, 31));
                end
            end
            if ($urandom_range(0, 39) == 0) begin
                md = 2'($urandom_range(0, 3));
            end
        end
        rst = 1'b0;
        ld  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_static();
        test_scroll();
        test_blink();
        test_load_step();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
